// File: rtl/alu_program_engine_if.sv
// Loader and result-handshake bundle for alu_program_engine.
// master: host loader / result consumer side. slave: the engine.
interface alu_program_engine_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 6
) ();

  logic                 prog_we;
  logic [ADDR_W-1:0]    prog_addr;
  logic [2*WIDTH+4:0]   prog_wdata;
  logic                 start;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     result;
  logic                 carry;
  logic                 zero;
  logic                 negative;
  logic [ADDR_W-1:0]    res_pc;
  logic                 done;

  modport master (
    output prog_we, prog_addr, prog_wdata, start, res_ready,
    input  busy, res_valid, result, carry, zero, negative, res_pc, done
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, res_ready,
    output busy, res_valid, result, carry, zero, negative, res_pc, done
  );

endinterface

// File: rtl/alu_program_engine.sv
// Sequenced ALU engine: a writable program memory is stepped by a PC, each
// instruction runs on a WIDTH-bit ALU and its result is offered on a
// valid/ready handshake. Instruction: {HALT, USE_ACC, OP[2:0], A, B}.
module alu_program_engine #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 6
) (
  input logic                 clock,
  input logic                 reset,
  alu_program_engine_if.slave io_bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned IW    = 2 * WIDTH + 5;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpShl = 3'b010;
  localparam logic [2:0] OpShr = 3'b011;
  localparam logic [2:0] OpAnd = 3'b100;
  localparam logic [2:0] OpOr  = 3'b101;
  localparam logic [2:0] OpXor = 3'b110;
  localparam logic [2:0] OpNot = 3'b111;

  typedef enum logic [1:0] {StIdle, StExec, StWait, StFin} state_e;

  state_e            r_state;
  state_e            w_state_next;

  // Program memory is deliberately left out of reset so a program survives it.
  logic [IW-1:0]     r_mem [DEPTH];

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_res_pc;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  r_result;
  logic              r_carry;
  logic              r_zero;
  logic              r_negative;
  logic              r_res_valid;
  logic              r_halt;

  logic [IW-1:0]     w_instr;
  logic              w_halt;
  logic              w_use_acc;
  logic [2:0]        w_op;
  logic [WIDTH-1:0]  w_a;
  logic [WIDTH-1:0]  w_b;
  logic [WIDTH:0]    w_sum;
  logic              w_shift_oob;
  logic [WIDTH-1:0]  w_alu;
  logic              w_carry;
  logic              w_accept;
  logic              w_last;

  assign w_instr     = r_mem[r_pc];
  assign w_halt      = w_instr[IW-1];
  assign w_use_acc   = w_instr[IW-2];
  assign w_op        = w_instr[IW-3 -: 3];
  assign w_a         = w_use_acc ? r_acc : w_instr[2*WIDTH-1 -: WIDTH];
  assign w_b         = w_instr[WIDTH-1:0];
  assign w_sum       = {1'b0, w_a} + {1'b0, w_b};
  assign w_shift_oob = (w_b >= WIDTH'(WIDTH));

  assign w_accept    = r_res_valid & io_bus.res_ready;
  // Program ends on a recorded HALT or at the last address; the PC never wraps.
  assign w_last      = r_halt | (r_pc == {ADDR_W{1'b1}});

  // ALU: result and carry for the instruction at the current PC.
  always_comb begin
    w_alu   = '0;
    w_carry = 1'b0;
    unique case (w_op)
      OpAdd: begin
        w_alu   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OpSub: begin
        w_alu   = w_a - w_b;
        w_carry = (w_a < w_b);
      end
      OpShl: w_alu = w_shift_oob ? '0 : (w_a << w_b);
      OpShr: w_alu = w_shift_oob ? '0 : (w_a >> w_b);
      OpAnd: w_alu = w_a & w_b;
      OpOr:  w_alu = w_a | w_b;
      OpXor: w_alu = w_a ^ w_b;
      OpNot: w_alu = ~w_a;
      default: w_alu = '0;
    endcase
  end

  // Program memory write port, open only while idle.
  always_ff @(posedge clock) begin
    if (r_state == StIdle && io_bus.prog_we) begin
      r_mem[io_bus.prog_addr] <= io_bus.prog_wdata;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (io_bus.start) w_state_next = StExec;
      StExec: w_state_next = StWait;
      StWait: if (w_accept) w_state_next = w_last ? StFin : StExec;
      StFin:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath registers: PC, accumulator and the held result/flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc        <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      r_negative  <= 1'b0;
      r_res_pc    <= '0;
      r_res_valid <= 1'b0;
      r_halt      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (io_bus.start) begin
            r_pc  <= '0;
            r_acc <= '0;
          end
        end
        StExec: begin
          r_result    <= w_alu;
          r_carry     <= w_carry;
          r_zero      <= (w_alu == '0);
          r_negative  <= w_alu[WIDTH-1];
          r_res_pc    <= r_pc;
          r_acc       <= w_alu;
          r_res_valid <= 1'b1;
          r_halt      <= w_halt;
        end
        StWait: begin
          if (w_accept) begin
            r_res_valid <= 1'b0;
            if (!w_last) begin
              r_pc <= r_pc + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.busy      = (r_state != StIdle);
  assign io_bus.done      = (r_state == StFin);
  assign io_bus.res_valid = r_res_valid;
  assign io_bus.result    = r_result;
  assign io_bus.carry     = r_carry;
  assign io_bus.zero      = r_zero;
  assign io_bus.negative  = r_negative;
  assign io_bus.res_pc    = r_res_pc;

endmodule
